// File: rtl/nalu_writer.sv
// nalu_writer: wraps an RBSP byte stream into an Annex-B NAL unit.
// Emits a 3- or 4-byte start code, the one-byte NAL header, then the
// payload with emulation-prevention bytes (0x03) inserted after any two
// consecutive zero bytes that would otherwise be followed by 0x00..0x03.
// A payload ending in two zeros gets a trailing 0x03 so the next start
// code cannot be mistaken for payload. Output is a single register stage
// with a valid/ready handshake; rbsp_ready is combinational because it
// depends on whether that register can take a byte in the current cycle.

module nalu_writer #(
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start_nalu,
  input  logic [1:0]         nal_ref_idc,
  input  logic [4:0]         nal_unit_type,
  input  logic               long_start_code,
  input  logic               rbsp_valid,
  input  logic [7:0]         rbsp_data,
  input  logic               rbsp_last,
  output logic               rbsp_ready,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  input  logic               byte_ready,
  output logic               busy,
  output logic               nalu_done,
  output logic [COUNT_W-1:0] byte_count,
  output logic [15:0]        epb_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SC    = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_PAY   = 3'd3;
  localparam logic [2:0] ST_EPB   = 3'd4;
  localparam logic [2:0] ST_TRAIL = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_r;
  logic [1:0]         sc_idx_r;
  logic               long_sc_r;
  logic [7:0]         hdr_r;
  logic [1:0]         zero_run_r;
  logic               out_valid_r;
  logic [7:0]         out_data_r;
  logic               busy_r;
  logic               done_r;
  logic [COUNT_W-1:0] byte_count_r;
  logic [15:0]        epb_count_r;

  logic               can_load_s;
  logic               epb_pending_s;
  logic               sc_last_s;
  logic               rbsp_ready_s;
  logic [1:0]         next_zero_run_s;
  logic               long_type_s;

  // Handshake qualifiers and the zero-run value after taking the current RBSP byte.
  always_comb begin
    can_load_s      = (!out_valid_r) || byte_ready;
    epb_pending_s   = (zero_run_r == 2'd2) && rbsp_valid && (rbsp_data <= 8'h03);
    sc_last_s       = long_sc_r ? (sc_idx_r == 2'd3) : (sc_idx_r == 2'd2);
    rbsp_ready_s    = (state_r == ST_PAY) && can_load_s && !epb_pending_s;
    long_type_s     = (nal_unit_type == 5'd7) || (nal_unit_type == 5'd8) ||
                      (nal_unit_type == 5'd9);
    next_zero_run_s = 2'd0;
    if (rbsp_data == 8'h00) begin
      if (zero_run_r == 2'd2) begin
        next_zero_run_s = 2'd2;
      end else begin
        next_zero_run_s = zero_run_r + 2'd1;
      end
    end else begin
      next_zero_run_s = 2'd0;
    end
  end

  // Sequencer, output register and per-NALU counters; everything freezes when ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sc_idx_r     <= 2'd0;
      long_sc_r    <= 1'b0;
      hdr_r        <= 8'h00;
      zero_run_r   <= 2'd0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      byte_count_r <= {COUNT_W{1'b0}};
      epb_count_r  <= 16'd0;
    end else if (ena) begin
      done_r <= 1'b0;

      // Drain: a byte accepted downstream empties the register unless reloaded below.
      if (out_valid_r && byte_ready) begin
        out_valid_r <= 1'b0;
        if (byte_count_r != COUNT_MAX) begin
          byte_count_r <= byte_count_r + COUNT_ONE;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (start_nalu) begin
            long_sc_r    <= long_start_code || long_type_s;
            hdr_r        <= {1'b0, nal_ref_idc, nal_unit_type};
            sc_idx_r     <= 2'd0;
            zero_run_r   <= 2'd0;
            byte_count_r <= {COUNT_W{1'b0}};
            epb_count_r  <= 16'd0;
            busy_r       <= 1'b1;
            state_r      <= ST_SC;
          end
        end

        ST_SC: begin
          if (can_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sc_last_s ? 8'h01 : 8'h00;
            sc_idx_r    <= sc_idx_r + 2'd1;
            if (sc_last_s) begin
              state_r <= ST_HDR;
            end
          end
        end

        ST_HDR: begin
          if (can_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= hdr_r;
            zero_run_r  <= 2'd0;
            state_r     <= ST_PAY;
          end
        end

        ST_PAY: begin
          if (can_load_s && rbsp_valid) begin
            out_valid_r <= 1'b1;
            if (epb_pending_s) begin
              // Insert 0x03 ahead of the RBSP byte, which stays on the input.
              out_data_r  <= 8'h03;
              zero_run_r  <= 2'd0;
              epb_count_r <= epb_count_r + 16'd1;
              state_r     <= ST_EPB;
            end else begin
              out_data_r <= rbsp_data;
              zero_run_r <= next_zero_run_s;
              if (rbsp_last) begin
                state_r <= (next_zero_run_s == 2'd2) ? ST_TRAIL : ST_DONE;
              end
            end
          end
        end

        ST_EPB: begin
          // The held RBSP byte is picked up once back in PAY.
          state_r <= ST_PAY;
        end

        ST_TRAIL: begin
          if (can_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= 8'h03;
            zero_run_r  <= 2'd0;
            epb_count_r <= epb_count_r + 16'd1;
            state_r     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (!out_valid_r) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rbsp_ready = rbsp_ready_s;
  assign byte_valid = out_valid_r;
  assign byte_data  = out_data_r;
  assign busy       = busy_r;
  assign nalu_done  = done_r;
  assign byte_count = byte_count_r;
  assign epb_count  = epb_count_r;

endmodule

// File: tb/tb_nalu_writer.sv
// Self-checking bench for nalu_writer: directed NALUs plus randomized
// payloads and handshake patterns, compared against a byte-level model of
// the Annex-B framing rules.

module tb_nalu_writer;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          start_nalu = 1'b0;
  logic [1:0]    nal_ref_idc = 2'd0;
  logic [4:0]    nal_unit_type = 5'd0;
  logic          long_start_code = 1'b0;
  logic          rbsp_valid = 1'b0;
  logic [7:0]    rbsp_data = 8'h00;
  logic          rbsp_last = 1'b0;
  logic          rbsp_ready;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready = 1'b1;
  logic          busy;
  logic          nalu_done;
  logic [CW-1:0] byte_count;
  logic [15:0]   epb_count;

  logic [7:0] rbsp_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_epb;
  int         n_pass  = 0;
  int         n_total = 0;

  nalu_writer #(.COUNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .start_nalu     (start_nalu),
    .nal_ref_idc    (nal_ref_idc),
    .nal_unit_type  (nal_unit_type),
    .long_start_code(long_start_code),
    .rbsp_valid     (rbsp_valid),
    .rbsp_data      (rbsp_data),
    .rbsp_last      (rbsp_last),
    .rbsp_ready     (rbsp_ready),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .busy           (busy),
    .nalu_done      (nalu_done),
    .byte_count     (byte_count),
    .epb_count      (epb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference framing: start code, header, payload with escapes, trailing escape.
  function automatic void build_expected(input logic [1:0] idc, input logic [4:0] typ,
                                         input logic lsc);
    int zeros;
    exp_q.delete();
    exp_epb = 0;
    if (lsc || typ == 5'd7 || typ == 5'd8 || typ == 5'd9) exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back({1'b0, idc, typ});
    zeros = 0;
    foreach (rbsp_q[i]) begin
      if (zeros >= 2 && rbsp_q[i] <= 8'h03) begin
        exp_q.push_back(8'h03);
        exp_epb++;
        zeros = 0;
      end
      exp_q.push_back(rbsp_q[i]);
      zeros = (rbsp_q[i] == 8'h00) ? zeros + 1 : 0;
    end
    if (zeros >= 2) begin
      exp_q.push_back(8'h03);
      exp_epb++;
    end
  endfunction

  // mode 0: free-running; 1: byte_ready toggles, ena low 3 cycles; 2: random.
  task automatic run_nalu(input logic [1:0] idc, input logic [4:0] typ, input logic lsc,
                          input int mode, input bit restart_mid, input int abort_after,
                          input string tag);
    int cyc;
    int idx;
    int done_n;
    int post;
    bit finished;
    build_expected(idc, typ, lsc);
    got_q.delete();
    idx = 0; done_n = 0; post = 0; cyc = 0; finished = 1'b0;
    @(negedge clk);
    rst = 1'b0; ena = 1'b1; byte_ready = 1'b1; rbsp_valid = 1'b0;
    start_nalu = 1'b1; nal_ref_idc = idc; nal_unit_type = typ; long_start_code = lsc;
    #4;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      if (cyc == 0) check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      start_nalu      = restart_mid && (cyc == 6);
      nal_ref_idc     = 2'($urandom_range(0, 3));
      nal_unit_type   = 5'($urandom_range(0, 31));
      long_start_code = 1'($urandom_range(0, 1));
      case (mode)
        0: begin
          ena = 1'b1; byte_ready = 1'b1; rbsp_valid = (idx < rbsp_q.size());
        end
        1: begin
          byte_ready = ((cyc % 2) == 0);
          ena        = !(cyc >= 12 && cyc < 15);
          rbsp_valid = (idx < rbsp_q.size());
        end
        default: begin
          ena        = ($urandom_range(0, 3) != 0);
          byte_ready = ($urandom_range(0, 2) != 0);
          rbsp_valid = (idx < rbsp_q.size()) && ($urandom_range(0, 3) != 0);
        end
      endcase
      rbsp_data = (idx < rbsp_q.size()) ? rbsp_q[idx] : 8'($urandom);
      rbsp_last = (idx == rbsp_q.size() - 1);
      #4;
      if (ena) begin
        if (byte_valid && byte_ready) got_q.push_back(byte_data);
        if (rbsp_valid && rbsp_ready) idx++;
        if (nalu_done) done_n++;
      end
      cyc++;
      if (abort_after >= 0 && idx >= abort_after) return;
      if (done_n > 0) begin
        post++;
        if (post >= 4) finished = 1'b1;
      end
    end
    rbsp_valid = 1'b0;
    check({tag, " completed"}, 32'(finished), 32'd1);
    check({tag, " length"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      check($sformatf("%s byte%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    check({tag, " byte_count"}, 32'(byte_count), 32'(exp_q.size()));
    check({tag, " epb_count"}, 32'(epb_count), 32'(exp_epb));
    check({tag, " done_pulses"}, 32'(done_n), 32'd1);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, " byte_data"}, 32'(byte_data), 32'd0);
    check({tag, " rbsp_ready"}, 32'(rbsp_ready), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " nalu_done"}, 32'(nalu_done), 32'd0);
    check({tag, " byte_count"}, 32'(byte_count), 32'd0);
    check({tag, " epb_count"}, 32'(epb_count), 32'd0);
  endtask

  initial begin
    int len;
    int r;
    logic [7:0] b;

    // Power-up reset.
    rst = 1'b1; ena = 1'b1;
    repeat (3) @(negedge clk);
    rbsp_valid = 1'b1;
    #4;
    check_reset_values("reset");
    rbsp_valid = 1'b0;

    // Short start code, plain payload.
    rbsp_q = '{8'h88, 8'h84};
    run_nalu(2'd3, 5'd5, 1'b0, 0, 1'b0, -1, "sps_short");
    check("sps_short count6", 32'(byte_count), 32'd6);
    check("sps_short epb0", 32'(epb_count), 32'd0);

    // SPS type forces long start code; one escape mid-payload.
    rbsp_q = '{8'h42, 8'h00, 8'h00, 8'h01, 8'h1E};
    run_nalu(2'd3, 5'd7, 1'b0, 0, 1'b0, -1, "type7");
    check("type7 count11", 32'(byte_count), 32'd11);
    check("type7 epb1", 32'(epb_count), 32'd1);

    // All-zero payload: one inline escape and one trailing escape.
    rbsp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_nalu(2'd2, 5'd1, 1'b0, 0, 1'b0, -1, "zeros");
    check("zeros count10", 32'(byte_count), 32'd10);
    check("zeros epb2", 32'(epb_count), 32'd2);

    // Same type-7 stimulus under back-pressure and an ena stall.
    rbsp_q = '{8'h42, 8'h00, 8'h00, 8'h01, 8'h1E};
    run_nalu(2'd3, 5'd7, 1'b0, 1, 1'b0, -1, "stall");

    // start_nalu while busy is ignored.
    rbsp_q = '{8'h42, 8'h00, 8'h00, 8'h01, 8'h1E};
    run_nalu(2'd3, 5'd7, 1'b0, 0, 1'b1, -1, "restart");

    // One-byte payload with forced long start code.
    rbsp_q = '{8'h00};
    run_nalu(2'd0, 5'd20, 1'b1, 0, 1'b0, -1, "one_byte");

    // Reset mid-payload with ena low, then a clean NALU.
    rbsp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h99};
    run_nalu(2'd1, 5'd1, 1'b0, 0, 1'b0, 3, "abort");
    @(negedge clk);
    rst = 1'b1; ena = 1'b0; rbsp_valid = 1'b1;
    @(negedge clk);
    #4;
    check_reset_values("midreset");
    rst = 1'b0; ena = 1'b1; rbsp_valid = 1'b0;
    rbsp_q = '{8'h88, 8'h84};
    run_nalu(2'd3, 5'd5, 1'b0, 0, 1'b0, -1, "after_reset");

    // Randomized payloads and handshakes, zero-heavy to exercise escapes.
    for (int n = 0; n < 20; n++) begin
      rbsp_q.delete();
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 7);
        if (r < 3) b = 8'h00;
        else if (r < 5) b = 8'($urandom_range(1, 3));
        else b = 8'($urandom_range(0, 255));
        rbsp_q.push_back(b);
      end
      run_nalu(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), -1,
               $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nalu_writer.md
NALU_WRITER -- requirements
Module: nalu_writer

Interface
REQ-001 Parameter COUNT_W, default 24, width of the per-NALU output byte counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ena  input  1  global enable; when low, all state, outputs and counters hold.
REQ-005 start_nalu  input  1  one-cycle request to begin a NALU; sampled only in IDLE.
REQ-006 nal_ref_idc  input  2  header field, latched on accepted start_nalu.
REQ-007 nal_unit_type  input  5  header field, latched on accepted start_nalu.
REQ-008 long_start_code  input  1  forces 4-byte start code, latched on accepted start_nalu.
REQ-009 rbsp_valid / rbsp_data / rbsp_last  input  1/8/1  RBSP byte stream; last marks final RBSP byte.
REQ-010 rbsp_ready  output  1  RBSP byte consumed on cycles where rbsp_valid && rbsp_ready && ena.
REQ-011 byte_valid / byte_data  output  1/8  registered Annex-B byte output.
REQ-012 byte_ready  input  1  downstream accepts byte when byte_valid && byte_ready && ena.
REQ-013 busy  output  1  high from accepted start_nalu until nalu_done.
REQ-014 nalu_done  output  1  one-cycle pulse after last byte of NALU is accepted downstream.
REQ-015 byte_count  output  COUNT_W  bytes accepted downstream for current/last NALU.
REQ-016 epb_count  output  16  emulation-prevention bytes inserted in current/last NALU.

Function
REQ-017 States: IDLE, SC (start code), HDR, PAY, EPB, TRAIL, DONE.
REQ-018 Output stage SHALL be a single register; it loads a new byte only when empty or its byte is accepted in the same cycle (no bubble under continuous byte_ready).
REQ-019 IDLE: start_nalu high -> latch fields, clear byte_count, epb_count, zero_run, go SC; start_nalu in any other state SHALL be ignored.
REQ-020 SC emits 00 00 00 01 when long_start_code=1 or nal_unit_type in {7,8,9}, else 00 00 01; then HDR.
REQ-021 HDR emits {1'b0, nal_ref_idc, nal_unit_type}, clears zero_run, then PAY.
REQ-022 PAY: rbsp_ready high only when output stage can load and no EPB is pending; rbsp_ready SHALL be low in all other states.
REQ-023 EPB rule: if zero_run==2 and rbsp_valid and rbsp_data<=8'h03, emit 8'h03 (state EPB for that cycle) without consuming the RBSP byte, clear zero_run, increment epb_count; the RBSP byte is emitted on the next load.
REQ-024 zero_run (2 bits, saturating at 2) increments on each emitted RBSP byte equal to 8'h00, clears on any nonzero RBSP byte or inserted 8'h03; start code bytes do not affect it.
REQ-025 On consuming byte with rbsp_last: if resulting zero_run==2 go TRAIL (emit one 8'h03, increment epb_count), else go DONE.
REQ-026 DONE: wait until output register empties (last byte accepted), then pulse nalu_done for one cycle, drop busy, return IDLE.
REQ-027 byte_count increments per downstream-accepted byte, saturating at all-ones; byte_count and epb_count hold after DONE until next accepted start_nalu.
REQ-028 rbsp_valid with rbsp_last on the first PAY byte is legal (1-byte payload); an empty payload is not supported.
REQ-029 byte_ready low holds byte_valid/byte_data stable; no byte is dropped or duplicated.
REQ-030 rbsp_data arriving while not in PAY SHALL be neither consumed nor emitted.

Reset
REQ-031 rst high SHALL, at the clock edge regardless of ena or state (including mid-NALU), force IDLE, byte_valid=0, byte_data=0, rbsp_ready=0, busy=0, nalu_done=0, zero_run=0, byte_count=0, epb_count=0; any partial NALU is discarded.

Verification
REQ-032 start type=5, idc=3, short SC, RBSP {88,84}, byte_ready=1 -> 00 00 01 65 88 84, byte_count=6, epb_count=0, one nalu_done.
REQ-033 type=7, idc=3, RBSP {42,00,00,01,1E} -> 00 00 00 01 67 42 00 00 03 01 1E, epb_count=1.
REQ-034 type=1, idc=2, RBSP {00,00,00,00} -> 00 00 01 41 00 00 03 00 00 03, epb_count=2 (second via TRAIL), byte_count=10.
REQ-035 REQ-033 stimulus with byte_ready toggling 1/0 every cycle and ena low for 3 cycles mid-payload -> identical byte sequence, no duplicates.
REQ-036 rst asserted during PAY of 8-byte NALU -> next cycle all outputs at reset values; subsequent NALU from REQ-032 output exactly.
REQ-037 start_nalu pulsed again while busy -> ignored; byte_count and sequence of current NALU unchanged.
